// File: rtl/approx_pkg.sv
// Shared constants and FSM state type for the approximate unsigned divider.
// Contents:
//   OPW      operand / quotient width (8)
//   SEGW     normalised segment width (4)
//   SHW      segment shift width (3, shift range 0..4)
//   DIVW     remainder width during restoring division (SEGW + 1)
//   state_t  divider FSM state encoding
package approx_pkg;

    localparam int unsigned OPW  = 8;
    localparam int unsigned SEGW = 4;
    localparam int unsigned SHW  = 3;
    localparam int unsigned DIVW = SEGW + 1;

    typedef enum logic [2:0] {
        StIdle,
        StNorm,
        StDiv,
        StCorr,
        StDone
    } state_t;

endpackage

// File: rtl/approx_seg_sel.sv
// Leading-one segment selector.
// Picks the 4-bit window whose MSB is the operand's leading one. Operands
// below 16 are passed through unshifted.
// Ports:
//   x      in   8  operand
//   seg    out  4  selected segment, (x >> shift)[3:0]
//   shift  out  3  right shift applied, 0..4
module approx_seg_sel
    import approx_pkg::*;
(
    input  logic [OPW-1:0]  x,
    output logic [SEGW-1:0] seg,
    output logic [SHW-1:0]  shift
);

    always_comb begin
        seg   = x[3:0];
        shift = 3'd0;
        if (x[7]) begin
            seg   = x[7:4];
            shift = 3'd4;
        end else if (x[6]) begin
            seg   = x[6:3];
            shift = 3'd3;
        end else if (x[5]) begin
            seg   = x[5:2];
            shift = 3'd2;
        end else if (x[4]) begin
            seg   = x[4:1];
            shift = 3'd1;
        end
    end

endmodule

// File: rtl/unsigned_approx_div.sv
// Approximate 8-bit unsigned divider.
// Both operands are reduced to 4-bit leading-one segments, the segments are
// divided by an 8-step restoring divider into a 4.4 fixed-point quotient, and
// the quotient is rescaled by the segment exponent difference. Fixed latency:
// NORM (1) + DIV (8) + CORR (1), then DONE holds the result until taken.
// Build option: define APPROX_DIV_ROUND_EN for round-half-up rescaling;
// otherwise the rescale truncates. Latency is identical in both builds.
// Ports:
//   clk        in   1  clock, rising edge
//   rst        in   1  asynchronous active-high reset
//   in_valid   in   1  operands valid
//   in_ready   out  1  high only in IDLE
//   A          in   8  dividend
//   B          in   8  divisor
//   out_valid  out  1  result valid (DONE)
//   out_ready  in   1  consumer accepts result
//   Y          out  8  approximate quotient (8'hFF on divide-by-zero)
//   dz         out  1  divide-by-zero flag
module unsigned_approx_div
    import approx_pkg::*;
(
    input  logic           clk,
    input  logic           rst,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [OPW-1:0] A,
    input  logic [OPW-1:0] B,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [OPW-1:0] Y,
    output logic           dz
);

    state_t          state_q;
    logic [OPW-1:0]  a_q, b_q;
    logic [SEGW-1:0] bseg_q;
    logic [3:0]      e_q;      // two's complement, -4..+4
    logic            bz_q;
    logic [OPW-1:0]  num_q;    // dividend bits still to shift in, MSB first
    logic [DIVW-1:0] rem_q;
    logic [OPW-1:0]  qf_q;     // 4.4 fixed-point segment quotient
    logic [2:0]      cnt_q;

    logic [SEGW-1:0] aseg, bseg;
    logic [SHW-1:0]  sa, sb;

    approx_seg_sel u_seg_a (
        .x     (a_q),
        .seg   (aseg),
        .shift (sa)
    );

    approx_seg_sel u_seg_b (
        .x     (b_q),
        .seg   (bseg),
        .shift (sb)
    );

    // One restoring-division step.
    logic [DIVW-1:0] rem_sh, rem_nx;
    logic            q_bit;

    always_comb begin
        rem_sh = {rem_q[DIVW-2:0], num_q[OPW-1]};
        q_bit  = (rem_sh >= {1'b0, bseg_q});
        rem_nx = q_bit ? (rem_sh - {1'b0, bseg_q}) : rem_sh;
    end

    // Rescale: shift right by 4-E (0..8); 4-bit wraparound yields 0..8 directly.
    logic [3:0]     corr_sh;
    logic [OPW-1:0] y_corr;
`ifdef APPROX_DIV_ROUND_EN
    logic [OPW:0]   rnd_sum, rnd_res;
`endif

    always_comb begin
        corr_sh = 4'd4 - e_q;
`ifdef APPROX_DIV_ROUND_EN
        rnd_sum = {1'b0, qf_q};
        if (corr_sh != 4'd0) begin
            rnd_sum = {1'b0, qf_q} + (9'd1 << (corr_sh - 4'd1));
        end
        rnd_res = rnd_sum >> corr_sh;
        y_corr  = rnd_res[OPW] ? 8'hFF : rnd_res[OPW-1:0];
`else
        y_corr  = qf_q >> corr_sh;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= StIdle;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            Y         <= '0;
            dz        <= 1'b0;
            a_q       <= '0;
            b_q       <= '0;
            bseg_q    <= '0;
            e_q       <= '0;
            bz_q      <= 1'b0;
            num_q     <= '0;
            rem_q     <= '0;
            qf_q      <= '0;
            cnt_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q      <= A;
                        b_q      <= B;
                        in_ready <= 1'b0;
                        state_q  <= StNorm;
                    end
                end
                StNorm: begin
                    bseg_q  <= bseg;
                    e_q     <= {1'b0, sa} - {1'b0, sb};
                    bz_q    <= (b_q == '0);
                    num_q   <= {aseg, 4'b0000};
                    rem_q   <= '0;
                    qf_q    <= '0;
                    cnt_q   <= '0;
                    state_q <= StDiv;
                end
                StDiv: begin
                    rem_q <= rem_nx;
                    num_q <= {num_q[OPW-2:0], 1'b0};
                    qf_q  <= {qf_q[OPW-2:0], q_bit};
                    cnt_q <= cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        state_q <= StCorr;
                    end
                end
                StCorr: begin
                    Y         <= bz_q ? 8'hFF : y_corr;
                    dz        <= bz_q;
                    out_valid <= 1'b1;
                    state_q   <= StDone;
                end
                StDone: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state_q   <= StIdle;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule
